// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response handshakes for two requesters plus the
// single-port data memory drive. slave = arbiter side, master = requesters/memory.
interface dmem_arbiter_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         Req0Valid;
    logic         Req0Ready;
    logic         Req0Write;
    logic         Req0Lock;
    logic [A-1:0] Req0Addr;
    logic [W-1:0] Req0WData;
    logic         Req1Valid;
    logic         Req1Ready;
    logic         Req1Write;
    logic         Req1Lock;
    logic [A-1:0] Req1Addr;
    logic [W-1:0] Req1WData;
    logic         Rsp0Valid;
    logic [W-1:0] Rsp0Data;
    logic         Rsp1Valid;
    logic [W-1:0] Rsp1Data;
    logic         MemWriteEn;
    logic [A-1:0] MemAddress;
    logic [W-1:0] MemDataIn;
    logic [W-1:0] MemDataOut;

    modport slave (
        input  Req0Valid, Req0Write, Req0Lock, Req0Addr, Req0WData,
        input  Req1Valid, Req1Write, Req1Lock, Req1Addr, Req1WData,
        input  MemDataOut,
        output Req0Ready, Req1Ready,
        output Rsp0Valid, Rsp0Data, Rsp1Valid, Rsp1Data,
        output MemWriteEn, MemAddress, MemDataIn
    );

    modport master (
        output Req0Valid, Req0Write, Req0Lock, Req0Addr, Req0WData,
        output Req1Valid, Req1Write, Req1Lock, Req1Addr, Req1WData,
        output MemDataOut,
        input  Req0Ready, Req1Ready,
        input  Rsp0Valid, Rsp0Data, Rsp1Valid, Rsp1Data,
        input  MemWriteEn, MemAddress, MemDataIn
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between requester 0
// (load/store unit) and requester 1 (init/DMA loader), one access per cycle.
// Ports: Clk; Reset (async, active-high); bus (dmem_arbiter_if.slave) with
//   Req0*/Req1* valid/ready requests, Rsp0*/Rsp1* one-cycle registered
//   responses, Mem* combinational memory drive and MemDataOut read data.
// Build option DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins when unlocked.
module dmem_arbiter #(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    dmem_arbiter_if.slave bus
);
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] lock_cnt;
    logic          lock_done;
    logic          gnt0;
    logic          gnt1;
    logic          mem_we;
    logic [A-1:0]  mem_addr;
    logic [W-1:0]  mem_din;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [W-1:0]  rsp0_data;
    logic [W-1:0]  rsp1_data;

    // Counter has reached the hold limit: this is the last locked cycle.
    assign lock_done = (lock_cnt == CNT_LAST);

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Index of the requester granted most recently; 1 out of reset so
    // requester 0 wins the first contention.
    logic last_grant;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_nx = state;
        unique case (state)
            LOCK0: begin
                gnt0 = bus.Req0Valid & ~Reset;
                if ((gnt0 & ~bus.Req0Lock) | lock_done) begin
                    state_nx = OPEN;
                end
            end
            LOCK1: begin
                gnt1 = bus.Req1Valid & ~Reset;
                if ((gnt1 & ~bus.Req1Lock) | lock_done) begin
                    state_nx = OPEN;
                end
            end
            default: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                gnt0 = bus.Req0Valid & ~Reset;
`else
                gnt0 = bus.Req0Valid & ~Reset &
                       (~bus.Req1Valid | last_grant);
`endif
                gnt1 = bus.Req1Valid & ~Reset & ~gnt0;
                if (gnt0 & bus.Req0Lock) begin
                    state_nx = LOCK0;
                end else if (gnt1 & bus.Req1Lock) begin
                    state_nx = LOCK1;
                end
            end
        endcase
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_we   = bus.Req0Write;
            mem_addr = bus.Req0Addr;
            mem_din  = bus.Req0WData;
        end else if (gnt1) begin
            mem_we   = bus.Req1Write;
            mem_addr = bus.Req1Addr;
            mem_din  = bus.Req1WData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= OPEN;
            lock_cnt <= '0;
        end else begin
            state <= state_nx;
            // Cleared while unlocked and on entry; saturates at the limit.
            if (state == OPEN || state_nx == OPEN) begin
                lock_cnt <= '0;
            end else if (!lock_done) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= gnt0;
            rsp1_valid <= gnt1;
            // Writes echo their data; reads capture the memory output.
            if (gnt0) begin
                rsp0_data <= bus.Req0Write ? bus.Req0WData : bus.MemDataOut;
            end
            if (gnt1) begin
                rsp1_data <= bus.Req1Write ? bus.Req1WData : bus.MemDataOut;
            end
        end
    end

    assign bus.Req0Ready  = gnt0;
    assign bus.Req1Ready  = gnt1;
    assign bus.MemWriteEn = mem_we;
    assign bus.MemAddress = mem_addr;
    assign bus.MemDataIn  = mem_din;
    assign bus.Rsp0Valid  = rsp0_valid;
    assign bus.Rsp1Valid  = rsp1_valid;
    assign bus.Rsp0Data   = rsp0_data;
    assign bus.Rsp1Data   = rsp1_data;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port 256×8 data memory between two requesters: requester 0, the core load/store unit, and requester 1, the init/DMA loader. Each cycle it grants at most one access, drives the memory's address, write-enable and write-data combinationally, and registers one response per accepted access. An optional lock keeps the memory with one requester across a read-modify-write sequence, with a bounded hold time.

## Interface
- W, 8, data width (matches memory entry width)
- A, 8, address width (2**A entries)
- LOCK_MAX, 4, maximum consecutive cycles a lock may be held before forced release (≥1)

- Clk  input  1  single clock, all state on posedge
- Reset  input  1  asynchronous, active-high
- Req0Valid / Req1Valid  input  1  request present
- Req0Ready / Req1Ready  output  1  request accepted this cycle (combinational)
- Req0Write / Req1Write  input  1  1 = write, 0 = read
- Req0Lock / Req1Lock  input  1  keep ownership after this access
- Req0Addr / Req1Addr  input  A  memory address
- Req0WData / Req1WData  input  W  write data
- Rsp0Valid / Rsp1Valid  output  1  one-cycle response pulse
- Rsp0Data / Rsp1Data  output  W  read data, or echoed write data for writes
- MemWriteEn  output  1  to memory write enable
- MemAddress  output  A  to memory address
- MemDataIn  output  W  to memory write data
- MemDataOut  input  W  combinational read data from memory

## Operation
- Handshake: a request transfers on a posedge where ReqNValid && ReqNReady. The requester holds Valid and all fields stable until then. At most one Ready is high per cycle.
- FSM states:
  - OPEN: round-robin between requesters.
  - LOCK0: only requester 0 may be granted.
  - LOCK1: only requester 1 may be granted.
- OPEN arbitration:
  - One Valid: that requester wins.
  - Both Valid: the requester not granted last wins (LastGrant register).
- LOCKn: Ready of the other requester is forced 0 even if n is idle.
- Transitions:
  - OPEN → LOCKn when n is accepted with ReqNLock=1.
  - LOCKn → OPEN when n is accepted with ReqNLock=0, or when LockCnt reaches LOCK_MAX-1 without that release (forced release).
  - LOCKn → LOCKn when n is accepted with Lock=1 and the limit is not reached.
- LockCnt:
  - Cleared on entering LOCKn.
  - Increments each cycle in LOCKn.
  - Saturates, no wrap.
  - Acceptance in LOCKn does not reset it.
- Memory drive:
  - With a grant: MemAddress = winner Addr, MemDataIn = winner WData, MemWriteEn = winner Write.
  - With no grant: MemWriteEn=0, MemAddress=0, MemDataIn=0.
- Response:
  - On acceptance, RspNValid=1 the next cycle for exactly one cycle.
  - RspNData is registered: MemDataOut sampled at the accepting edge for reads, or WData for writes.
  - RspNData holds its value when RspNValid=0.
- LastGrant updates on every acceptance, including inside LOCK.

## Timing
- Reset values:
  - State=OPEN, LastGrant=1 (requester 0 wins the first contention), LockCnt=0.
  - Rsp0Valid=Rsp1Valid=0, Rsp0Data=Rsp1Data=0.
- While Reset is high: both Ready=0 and MemWriteEn=0.
- Grant latency: 0 cycles, since Ready is combinational in the cycle Valid is seen, subject to arbitration.
- Throughput: one access per cycle total. Back-to-back accesses by the same requester are allowed when the other is idle or locked out.
- Response latency: exactly 1 cycle after acceptance.
- Read-after-write to the same address in consecutive cycles returns the new data, because the write lands at the accepting edge.
- Forced release: the other requester can be granted in the first cycle after LockCnt hits the limit.
- Reset mid-lock: the lock is abandoned, and a pending response pulse is cleared immediately (asynchronous).

## Configuration
- DMEM_ARB_FIXED_PRIO_EN:
  - Defined: OPEN-state arbitration is fixed priority, requester 0 always beats requester 1, and LastGrant is unused. LOCK behaviour is unchanged.
  - Undefined (default): round-robin as above.

## Test plan
- Reset then single read: Req0 read Addr=0x10, memory holds 0xA5 → Req0Ready=1 same cycle, MemWriteEn=0, next cycle Rsp0Valid=1, Rsp0Data=0xA5.
- Contention: both Valid for 4 cycles, Req0 write 0x20←0x11, Req1 reads → grants in order 0,1,0,1; Req1's read of 0x20 returns 0x11. With DMEM_ARB_FIXED_PRIO_EN, Req0 is granted all 4 cycles.
- Lock RMW: Req1 read 0x30 with Lock=1, Req0 Valid continuously, Req1 write 0x30 with Lock=0 two cycles later → Req0Ready=0 throughout LOCK1, Req0 granted the cycle after the unlocking write.
- Forced release: Req1 locks and then drops Valid, LOCK_MAX=4 → Req0 is blocked exactly 4 cycles, then granted.
- Reset mid-lock: assert Reset while in LOCK0 with Rsp0Valid high → Rsp0Valid=0 immediately. After Reset deasserts, Req1 is granted when Req0 is idle.
- Write ack: Req0 write 0xFF←0x5A → MemWriteEn=1 for one cycle, next cycle Rsp0Valid=1, Rsp0Data=0x5A; a subsequent read of 0xFF returns 0x5A (address wrap boundary).
